// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder controller. A single 1-bit full-adder cell is sequenced
//   across WIDTH cycles, LSB first. This trades latency for area compared with
//   a parallel ripple adder. The block owns the operand shift registers, the
//   carry flop, the bit counter and the control FSM.
//
//   Sequence: IDLE --start--> RUN (WIDTH cycles) --> DONE (1 cycle) --> IDLE
//   Throughput is one add per WIDTH+2 cycles.
//
// Parameters
//   WIDTH   operand/result width in bits, legal range 2..32 (default 8)
//
// Ports
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      add request, sampled only in IDLE
//   a       in   WIDTH  operand A, captured when start is accepted
//   b       in   WIDTH  operand B, captured when start is accepted
//   cin     in   1      carry-in, captured when start is accepted
//   busy    out  1      high in RUN and DONE
//   done    out  1      one-cycle pulse: sum/cout valid
//   sum     out  WIDTH  result, held from done until the next accepted start
//   cout    out  1      carry out of the MSB, held with sum
//   ovf     out  1      two's-complement overflow, held with sum
//                       (present only when SERIAL_ADD_OVF_EN is defined)
//
// Build option
//   SERIAL_ADD_OVF_EN  when defined, adds the ovf port and its flop.
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             bit_sum;
    logic             bit_carry;
    logic             last_bit;
    logic             accept;

    // The single full-adder cell: always works on bit 0 of the shift registers.
    assign bit_sum   = a_sh[0] ^ b_sh[0] ^ carry;
    assign bit_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign last_bit  = (cnt == LAST);
    assign accept    = (state == IDLE) && start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, serial add, result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            carry <= bit_carry;
            // Sum enters at the MSB; after WIDTH shifts the first (LSB) result
            // bit has reached position 0.
            sum   <= {bit_sum, sum[WIDTH-1:1]};
            if (last_bit) begin
                cout <= bit_carry;
`ifdef SERIAL_ADD_OVF_EN
                // carry is the carry into the MSB on this final cycle.
                ovf  <= carry ^ bit_carry;
`endif
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
